// File: rtl/stopwatch_pkg.sv
// Shared constants for the BCD stopwatch: FSM encoding and per-digit limits.
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit counting 0..MAX, with a combinational carry into the next digit.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 4'd0;
    end else if (clr) begin
      q_reg <= 4'd0;
    end else if (inc) begin
      q_reg <= (q_reg == MAX) ? 4'd0 : q_reg + 4'd1;
    end
  end

  assign q     = q_reg;
  assign carry = inc & (q_reg == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch counting prescaled rising edges of a slow tick_in square wave.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10,
  parameter int PW  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap
);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] prescale_reg;
  logic          tick_q_reg;
  logic          running_reg;
  logic          wrap_reg;
  logic          rise;
  logic          count_en;
  logic          unit;
  logic [4:0]    inc_chain;
  logic [3:0]    digit_q [4];

  assign rise = tick_in & ~tick_q_reg;

  // State is sampled before the transition, so a rise coinciding with a pause still counts.
  assign count_en = (state_reg == ST_RUN) & rise & ~clear;
  assign unit     = count_en & (prescale_reg == PRE_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (start_stop) state_next = ST_PAUSED;
      ST_PAUSED: if (start_stop) state_next = ST_RUN;
      default:   state_next = start_stop ? ST_RUN : ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      prescale_reg <= '0;
      tick_q_reg   <= 1'b0;
      running_reg  <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_q_reg  <= tick_in;
      running_reg <= (state_next == ST_RUN);
      wrap_reg    <= inc_chain[4];
      if (clear || (state_reg != ST_RUN && state_reg != ST_PAUSED)) begin
        prescale_reg <= '0;
      end else if (count_en) begin
        prescale_reg <= unit ? '0 : prescale_reg + 1'b1;
      end
    end
  end

  assign inc_chain[0] = unit;

  // Even positions are ones digits (0..9), odd positions are tens digits (0..5).
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    bcd_digit #(
      .MAX((gi % 2 == 0) ? BCD_MAX9 : BCD_MAX5)
    ) u_digit (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clear),
      .inc  (inc_chain[gi]),
      .q    (digit_q[gi]),
      .carry(inc_chain[gi+1])
    );
  end

  assign sec_ones = digit_q[0];
  assign sec_tens = digit_q[1];
  assign min_ones = digit_q[2];
  assign min_tens = digit_q[3];
  assign running  = running_reg;
  assign wrap     = wrap_reg;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Drives three stopwatches (DIV = 10, 4, 1) from one stimulus stream and checks every cycle.
module tb_stopwatch_bcd;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;

  logic [3:0] so_w [N];
  logic [3:0] st_w [N];
  logic [3:0] mo_w [N];
  logic [3:0] mt_w [N];
  logic       run_w [N];
  logic       wrap_w [N];

  int checks = 0;
  int failures = 0;

  // Reference model: a plain seconds total plus a rise counter per instance.
  int div_m [N] = '{10, 4, 1};
  int st_m [N];     // 0 idle, 1 run, 2 paused
  int pre_m [N];
  int secs_m [N];
  bit wrap_m [N];
  bit tick_prev_m;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    stopwatch_bcd #(
      .DIV((gi == 0) ? 10 : (gi == 1) ? 4 : 1),
      .PW (10)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_in   (tick_in),
      .start_stop(start_stop),
      .clear     (clear),
      .sec_ones  (so_w[gi]),
      .sec_tens  (st_w[gi]),
      .min_ones  (mo_w[gi]),
      .min_tens  (mt_w[gi]),
      .running   (run_w[gi]),
      .wrap      (wrap_w[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int s);
    logic [15:0] r;
    r[15:12] = 4'(s / 600);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  task automatic model_reset();
    tick_prev_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      st_m[i] = 0; pre_m[i] = 0; secs_m[i] = 0; wrap_m[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit r;
    r = tick_in && !tick_prev_m;
    tick_prev_m = tick_in;
    for (int i = 0; i < N; i++) begin
      wrap_m[i] = 1'b0;
      if (clear) begin
        st_m[i] = 0; pre_m[i] = 0; secs_m[i] = 0;
      end else begin
        if (st_m[i] == 1 && r) begin
          pre_m[i]++;
          if (pre_m[i] == div_m[i]) begin
            pre_m[i] = 0;
            secs_m[i]++;
            if (secs_m[i] == 3600) begin
              secs_m[i] = 0;
              wrap_m[i] = 1'b1;
            end
          end
        end
        if (start_stop) st_m[i] = (st_m[i] == 1) ? 2 : 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("dut%0d_digits", i), {16'd0, mt_w[i], mo_w[i], st_w[i], so_w[i]},
            {16'd0, bcd_of(secs_m[i])});
      check($sformatf("dut%0d_running", i), {31'd0, run_w[i]}, {31'd0, (st_m[i] == 1)});
      check($sformatf("dut%0d_wrap", i), {31'd0, wrap_w[i]}, {31'd0, wrap_m[i]});
    end
  endtask

  task automatic step(input logic t, input logic ss, input logic cl);
    tick_in = t; start_stop = ss; clear = cl;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic rises(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      for (int h = 0; h < hi; h++) step(1'b1, 1'b0, 1'b0);
      for (int l = 0; l < lo; l++) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int hold;
    logic t;
    model_reset();
    #23;
    compare_all();
    $display("reset: checked reset values");
    rst_n = 1'b1;
    #3;

    // Test 1: DIV=10 instance, tick period 10 clk.
    step(1'b0, 1'b1, 1'b0);
    rises(100, 5, 5);
    check("t1_sec_tens_div10", {28'd0, st_w[0]}, 32'd1);
    $display("test1: 100 rises at period 10, dut0 sec=%0h%0h", st_w[0], so_w[0]);

    // Test 2: long high level counts once.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 50; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t2_single_count_div1", {28'd0, so_w[2]}, 32'd1);
    $display("test2: held-high tick, dut2 sec_ones=%0d", so_w[2]);

    // Test 3: partial unit survives a pause; paused rises ignored.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    rises(2, 1, 2);
    step(1'b0, 1'b1, 1'b0);
    rises(5, 1, 2);
    step(1'b0, 1'b1, 1'b0);
    rises(2, 1, 2);
    check("t3_pause_div4", {28'd0, so_w[1]}, 32'd1);
    $display("test3: pause/resume, dut1 sec_ones=%0d", so_w[1]);

    // Test 4: full rollover on the DIV=1 instance.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    rises(3599, 1, 1);
    check("t4_5959", {16'd0, mt_w[2], mo_w[2], st_w[2], so_w[2]}, 32'h5959);
    step(1'b1, 1'b0, 1'b0);
    check("t4_wrap_pulse", {31'd0, wrap_w[2]}, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("t4_wrap_drop", {31'd0, wrap_w[2]}, 32'd0);
    check("t4_still_running", {31'd0, run_w[2]}, 32'd1);
    $display("test4: rollover, dut2 digits=%0h%0h%0h%0h", mt_w[2], mo_w[2], st_w[2], so_w[2]);

    // Test 5: clear + start_stop + rise together at 00:07.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    rises(7, 1, 1);
    step(1'b1, 1'b1, 1'b1);
    check("t5_clear_wins_run", {31'd0, run_w[2]}, 32'd0);
    check("t5_clear_digits", {28'd0, so_w[2]}, 32'd0);
    $display("test5: clear beats start_stop, dut2 running=%0d", run_w[2]);

    // Test 6: asynchronous reset mid-period at 12:34.
    step(1'b0, 1'b1, 1'b0);
    rises(754, 1, 1);
    check("t6_1234", {16'd0, mt_w[2], mo_w[2], st_w[2], so_w[2]}, 32'h1234);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    #2 rst_n = 1'b1;
    rises(20, 1, 1);
    check("t6_ignored_after_reset", {28'd0, so_w[2]}, 32'd0);
    $display("test6: async reset, dut2 digits=%0h%0h%0h%0h", mt_w[2], mo_w[2], st_w[2], so_w[2]);

    // Randomized run.
    hold = 0;
    t = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        t = ~t;
        hold = $urandom_range(1, 6);
      end
      hold--;
      step(t, ($urandom_range(0, 29) == 0), ($urandom_range(0, 299) == 0));
    end
    $display("random: 4000 cycles, dut0 secs model=%0d", secs_m[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
